// File: rtl/deser_pkg.sv
// -----------------------------------------------------------------------------
// deser_pkg
// Shared definitions for the 16-bit deserializer. The serializer bench uses
// the same package for the modifier encoding (0 = full 16-bit word).
//   DATA_W    : word width (fixed at 16)
//   MOD_W     : modifier width, $clog2(DATA_W)
//   FLUSH_GAP : idle cycles that close a partial word (1..15)
// -----------------------------------------------------------------------------
package deser_pkg;

  localparam int DATA_W    = 16;
  localparam int MOD_W     = 4;
  localparam int FLUSH_GAP = 4;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } deser_state_t;

  // Move the n low-order received bits of v up to the MSB end, zero-filling
  // below. Only called with n in 1..DATA_W-1.
  function automatic logic [DATA_W-1:0] left_align(
    input logic [DATA_W-1:0] v,
    input logic [MOD_W-1:0]  n
  );
    logic [MOD_W:0] shamt;
    shamt = (MOD_W+1)'(DATA_W) - {1'b0, n};
    return v << shamt;
  endfunction

endpackage

// File: rtl/deser_gap_timer.sv
// -----------------------------------------------------------------------------
// deser_gap_timer
// Saturating counter of consecutive idle cycles while a partial word is held.
//   clk_i     : clock, rising edge
//   rst_ni    : asynchronous active-low reset
//   clear_i   : restart the gap (a valid bit arrived, or no word is held)
//   tick_i    : one idle cycle inside a partial word
//   expired_o : this tick is the FLUSH_GAP-th consecutive idle cycle
// -----------------------------------------------------------------------------
module deser_gap_timer #(
  parameter int FLUSH_GAP = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic tick_i,
  output logic expired_o
);

  localparam int GAP_W = $clog2(FLUSH_GAP + 1);

  logic [GAP_W-1:0] gap_r;

  // Idle-cycle counter, held at FLUSH_GAP once reached.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gap_r <= '0;
    end else if (clear_i) begin
      gap_r <= '0;
    end else if (tick_i && (gap_r != GAP_W'(FLUSH_GAP))) begin
      gap_r <= gap_r + GAP_W'(1);
    end else begin
      gap_r <= gap_r;
    end
  end

  // Expiry is decoded from the tick that is about to reach FLUSH_GAP so that
  // the flush is registered on that same edge.
  always_comb begin
    expired_o = 1'b0;
    if (tick_i && !clear_i && (gap_r == GAP_W'(FLUSH_GAP - 1))) begin
      expired_o = 1'b1;
    end else begin
      expired_o = 1'b0;
    end
  end

endmodule

// File: rtl/deserializer.sv
// -----------------------------------------------------------------------------
// deserializer
// Rebuilds 16-bit words from an MSB-first serial stream. A full word is
// emitted on the edge that samples its 16th bit; a partial word is emitted,
// left-aligned with its bit count, after FLUSH_GAP consecutive idle cycles.
//   clk_i            : clock, rising edge
//   rst_ni           : asynchronous active-low reset
//   ser_data_i       : serial bit, sampled when ser_data_val_i = 1
//   ser_data_val_i   : serial bit valid
//   deser_data_o     : assembled word, first bit at [15], unused bits 0
//   deser_data_mod_o : number of valid bits, 0 encodes 16
//   deser_data_val_o : one-cycle strobe for deser_data_o/deser_data_mod_o
//   busy_o           : a partial word is held
// -----------------------------------------------------------------------------
module deserializer
  import deser_pkg::*;
#(
  parameter int DATA_W    = deser_pkg::DATA_W,
  parameter int MOD_W     = deser_pkg::MOD_W,
  parameter int FLUSH_GAP = deser_pkg::FLUSH_GAP
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ser_data_i,
  input  logic              ser_data_val_i,
  output logic [DATA_W-1:0] deser_data_o,
  output logic [MOD_W-1:0]  deser_data_mod_o,
  output logic              deser_data_val_o,
  output logic              busy_o
);

  deser_state_t      state_r, state_n;
  logic [MOD_W-1:0]  cnt_r, cnt_n;
  logic [DATA_W-1:0] shreg_r, shreg_n;
  logic [DATA_W-1:0] data_r, data_n;
  logic [MOD_W-1:0]  mod_r, mod_n;
  logic              val_r, val_n;
  logic              gap_clear_s, gap_tick_s, gap_expired_s;

  // The gap only counts inside a partial word; outside it is held cleared.
  assign gap_tick_s  = (state_r == COLLECT) && !ser_data_val_i;
  assign gap_clear_s = (state_r != COLLECT) || ser_data_val_i;

  deser_gap_timer #(
    .FLUSH_GAP (FLUSH_GAP)
  ) u_gap_timer (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (gap_clear_s),
    .tick_i    (gap_tick_s),
    .expired_o (gap_expired_s)
  );

  // State, shift register, bit count and registered output word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      shreg_r <= '0;
      data_r  <= '0;
      mod_r   <= '0;
      val_r   <= 1'b0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      shreg_r <= shreg_n;
      data_r  <= data_n;
      mod_r   <= mod_n;
      val_r   <= val_n;
    end
  end

  // Next-state and output-word decode. The strobe is cleared every cycle
  // unless a word completes; data/mod hold their last value otherwise.
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    shreg_n = shreg_r;
    data_n  = data_r;
    mod_n   = mod_r;
    val_n   = 1'b0;
    case (state_r)
      IDLE: begin
        if (ser_data_val_i) begin
          // Start clean so stale bits never reach a flushed word.
          shreg_n = {{(DATA_W-1){1'b0}}, ser_data_i};
          cnt_n   = MOD_W'(1);
          state_n = COLLECT;
        end else begin
          state_n = IDLE;
        end
      end
      COLLECT: begin
        if (ser_data_val_i) begin
          shreg_n = {shreg_r[DATA_W-2:0], ser_data_i};
          if (cnt_r == MOD_W'(DATA_W - 1)) begin
            // 16th bit: emit the whole word, the count wraps to 0 (mod 0).
            data_n  = {shreg_r[DATA_W-2:0], ser_data_i};
            mod_n   = '0;
            val_n   = 1'b1;
            cnt_n   = '0;
            state_n = IDLE;
          end else begin
            cnt_n   = cnt_r + MOD_W'(1);
          end
        end else if (gap_expired_s) begin
          data_n  = left_align(shreg_r, cnt_r);
          mod_n   = cnt_r;
          val_n   = 1'b1;
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          state_n = COLLECT;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign deser_data_o     = data_r;
  assign deser_data_mod_o = mod_r;
  assign deser_data_val_o = val_r;
  assign busy_o           = (state_r == COLLECT);

endmodule
